// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the 64-point FFT datapath.
//   DATA_WIDTH / TW_WIDTH / TW_FRAC / IDX_WIDTH : default datapath sizing
//   sat_max / sat_min                           : saturation limits of a widened sample
//   cplx_t                                      : widened complex sample {re, im}
package fft_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned TW_WIDTH   = 16;
    localparam int unsigned TW_FRAC    = 14;
    localparam int unsigned IDX_WIDTH  = 6;

    localparam logic [2*DATA_WIDTH-1:0] sat_max = {1'b0, {(2*DATA_WIDTH-1){1'b1}}};
    localparam logic [2*DATA_WIDTH-1:0] sat_min = {1'b1, {(2*DATA_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [2*DATA_WIDTH-1:0] re;
        logic [2*DATA_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmul_round_sat.sv
// cmul_round_sat: combinational rescale of one complex-product component.
// Arithmetic right shift by SHIFT, then saturation to a signed OUT_W result.
// Build option: TWIDDLE_CMUL_ROUND_EN defined -> round half up (add 2^(SHIFT-1)
// before the shift); undefined -> truncate toward -inf.
// Ports:
//   din_i  in  IN_W   signed sum (pr-pi or qr+qi)
//   dout_o out OUT_W  rescaled, saturated component
//   sat_o  out 1      result was clipped
module cmul_round_sat #(
    parameter int unsigned IN_W  = 49,
    parameter int unsigned SHIFT = 14,
    parameter int unsigned OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic        [OUT_W-1:0] dout_o,
    output logic                    sat_o
);

    // One extra bit so the rounding add can never wrap.
    localparam int unsigned EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] MAXV =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV =
        {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef TWIDDLE_CMUL_ROUND_EN
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
`endif

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shr;

    always_comb begin
        ext = {din_i[IN_W-1], din_i};
`ifdef TWIDDLE_CMUL_ROUND_EN
        rnd = ext + HALF;
`else
        rnd = ext;
`endif
        shr    = rnd >>> SHIFT;
        dout_o = shr[OUT_W-1:0];
        sat_o  = 1'b0;
        if (shr > MAXV) begin
            dout_o = {1'b0, {(OUT_W-1){1'b1}}};
            sat_o  = 1'b1;
        end else if (shr < MINV) begin
            dout_o = {1'b1, {(OUT_W-1){1'b0}}};
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/twiddle_cmul.sv
// twiddle_cmul: 3-stage pipelined complex multiply by a Q2.(TW_WIDTH-2) twiddle,
// with rescale/round/saturate back to 2*DATA_WIDTH and a 6-bit sample index tag.
// Build option: TWIDDLE_CMUL_ROUND_EN (round half up instead of truncation).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready = !out_valid || out_ready)
//   x_re, x_im            widened operand, two's complement
//   w_re, w_im            twiddle factor, signed
//   out_valid/out_ready   output handshake
//   y_re, y_im            result
//   y_idx                 sample index of the presented result
//   y_sat                 either result component was clipped
module twiddle_cmul #(
    parameter int unsigned DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int unsigned TW_WIDTH   = fft_pkg::TW_WIDTH,
    parameter int unsigned TW_FRAC    = fft_pkg::TW_FRAC,
    parameter int unsigned IDX_WIDTH  = fft_pkg::IDX_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] x_re,
    input  logic [2*DATA_WIDTH-1:0] x_im,
    input  logic [TW_WIDTH-1:0]     w_re,
    input  logic [TW_WIDTH-1:0]     w_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] y_re,
    output logic [2*DATA_WIDTH-1:0] y_im,
    output logic [IDX_WIDTH-1:0]    y_idx,
    output logic                    y_sat
);

    localparam int unsigned DW2 = 2 * DATA_WIDTH;
    localparam int unsigned PW  = DW2 + TW_WIDTH;
    localparam int unsigned SW  = PW + 1;

    logic en;

    // S1
    logic [DW2-1:0]      x_re_q, x_re_d, x_im_q, x_im_d;
    logic [TW_WIDTH-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
    logic                v1_q, v1_d;
    // S2
    logic [PW-1:0]       pr_q, pr_d, pi_q, pi_d, qr_q, qr_d, qi_q, qi_d;
    logic                v2_q, v2_d;
    // S3
    logic [DW2-1:0]      y_re_q, y_re_d, y_im_q, y_im_d;
    logic                y_sat_q, y_sat_d;
    logic                v3_q, v3_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    logic [PW-1:0]  xr_e, xi_e, wr_e, wi_e;
    logic [SW-1:0]  re_sum, im_sum;
    logic [DW2-1:0] re_rs, im_rs;
    logic           re_sat, im_sat;

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign y_sat     = y_sat_q;
    assign y_idx     = idx_q;

    always_comb begin
        x_re_d = x_re;
        x_im_d = x_im;
        w_re_d = w_re;
        w_im_d = w_im;
        v1_d   = in_valid;

        // Sign-extend to product width; the low PW bits of the unsigned product
        // equal the signed product.
        xr_e = {{TW_WIDTH{x_re_q[DW2-1]}}, x_re_q};
        xi_e = {{TW_WIDTH{x_im_q[DW2-1]}}, x_im_q};
        wr_e = {{DW2{w_re_q[TW_WIDTH-1]}}, w_re_q};
        wi_e = {{DW2{w_im_q[TW_WIDTH-1]}}, w_im_q};
        pr_d = xr_e * wr_e;
        pi_d = xi_e * wi_e;
        qr_d = xr_e * wi_e;
        qi_d = xi_e * wr_e;
        v2_d = v1_q;

        re_sum  = {pr_q[PW-1], pr_q} - {pi_q[PW-1], pi_q};
        im_sum  = {qr_q[PW-1], qr_q} + {qi_q[PW-1], qi_q};
        y_re_d  = re_rs;
        y_im_d  = im_rs;
        y_sat_d = re_sat | im_sat;
        v3_d    = v2_q;

        idx_d = idx_q;
        if (v3_q && out_ready) begin
            idx_d = idx_q + IDX_WIDTH'(1);
        end
    end

    cmul_round_sat #(
        .IN_W  (SW),
        .SHIFT (TW_FRAC),
        .OUT_W (DW2)
    ) u_rs_re (
        .din_i  (re_sum),
        .dout_o (re_rs),
        .sat_o  (re_sat)
    );

    cmul_round_sat #(
        .IN_W  (SW),
        .SHIFT (TW_FRAC),
        .OUT_W (DW2)
    ) u_rs_im (
        .din_i  (im_sum),
        .dout_o (im_rs),
        .sat_o  (im_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x_re_q  <= '0;
            x_im_q  <= '0;
            w_re_q  <= '0;
            w_im_q  <= '0;
            v1_q    <= 1'b0;
            pr_q    <= '0;
            pi_q    <= '0;
            qr_q    <= '0;
            qi_q    <= '0;
            v2_q    <= 1'b0;
            y_re_q  <= '0;
            y_im_q  <= '0;
            y_sat_q <= 1'b0;
            v3_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (en) begin
                x_re_q  <= x_re_d;
                x_im_q  <= x_im_d;
                w_re_q  <= w_re_d;
                w_im_q  <= w_im_d;
                v1_q    <= v1_d;
                pr_q    <= pr_d;
                pi_q    <= pi_d;
                qr_q    <= qr_d;
                qi_q    <= qi_d;
                v2_q    <= v2_d;
                y_re_q  <= y_re_d;
                y_im_q  <= y_im_d;
                y_sat_q <= y_sat_d;
                v3_q    <= v3_d;
            end
            idx_q <= idx_d;
        end
    end

endmodule

// File: tb/tb_twiddle_cmul.sv
// Self-checking bench for twiddle_cmul with directed vectors.
// Honours TWIDDLE_CMUL_ROUND_EN for the vectors whose result depends on rounding.
module tb_twiddle_cmul;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_re, x_im;
    logic [15:0] w_re, w_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y_re, y_im;
    logic [5:0]  y_idx;
    logic        y_sat;

    int checks = 0;
    int errors = 0;
    int unsigned idx_model = 0;

    typedef struct packed {
        logic [31:0] xr;
        logic [31:0] xi;
        logic [15:0] wr;
        logic [15:0] wi;
        logic [31:0] er;
        logic [31:0] ei;
        logic        es;
    } vec_t;

    always #5 clk = ~clk;

    twiddle_cmul #(
        .DATA_WIDTH (16),
        .TW_WIDTH   (16),
        .TW_FRAC    (14),
        .IDX_WIDTH  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .y_idx     (y_idx),
        .y_sat     (y_sat)
    );

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        x_re = '0; x_im = '0; w_re = '0; w_im = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (y_re !== 32'h0 || y_im !== 32'h0) begin errors++; $display("FAIL reset_y: got %h/%h want 0/0", y_re, y_im); end
        checks++; if (y_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", y_idx); end
        checks++; if (y_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", y_sat); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        idx_model = 0;
    endtask

    task automatic test_stream;
        int sent = 0, rcv = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
        out_ready = 1'b1; w_re = 16'h0000; w_im = 16'h4000;  // multiply by j
        while (rcv < 70 && cyc < 200) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                checks++; if (y_re !== 32'(rcv * 3)) begin errors++; $display("FAIL stream_re[%0d]: got %h want %h", rcv, y_re, 32'(rcv * 3)); end
                checks++; if (y_im !== 32'(rcv * 1000 + 7)) begin errors++; $display("FAIL stream_im[%0d]: got %h want %h", rcv, y_im, 32'(rcv * 1000 + 7)); end
                checks++; if (y_idx !== 6'(idx_model)) begin errors++; $display("FAIL stream_idx[%0d]: got %0d want %0d", rcv, y_idx, 6'(idx_model)); end
                checks++; if (y_sat !== 1'b0) begin errors++; $display("FAIL stream_sat[%0d]: got %b want 0", rcv, y_sat); end
                rcv++; idx_model++;
            end
            if (sent < 70) begin
                in_valid = 1'b1;
                x_re = 32'(sent * 1000 + 7);
                x_im = 32'(-(sent * 3));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        checks++; if (rcv != 70) begin errors++; $display("FAIL stream_count: got %0d want 70", rcv); end
        checks++; if (first_cyc != 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", first_cyc); end
        checks++; if (last_cyc - first_cyc != 69) begin errors++; $display("FAIL stream_throughput: span %0d want 69", last_cyc - first_cyc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_directed;
        vec_t v[9];
        int lat;
        v[0] = '{32'h00010000, 32'h0, 16'h4000, 16'h0, 32'h00010000, 32'h0, 1'b0};
        v[1] = '{32'h00010000, 32'h00010000, 16'h0, 16'h4000, 32'hFFFF0000, 32'h00010000, 1'b0};
        v[2] = '{32'h7FFFFFFF, 32'h80000000, 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1};
        v[3] = '{32'h80000000, 32'h0, 16'h7FFF, 16'h0, 32'h80000000, 32'h0, 1'b1};
        v[4] = '{32'h40000000, 32'h0, 16'h8000, 16'h0, 32'h80000000, 32'h0, 1'b0};
        v[5] = '{32'h7FFFFFFF, 32'h0, 16'h4000, 16'h0, 32'h7FFFFFFF, 32'h0, 1'b0};
`ifdef TWIDDLE_CMUL_ROUND_EN
        v[6] = '{32'hFFFFFFFF, 32'h0, 16'h0001, 16'h0, 32'h00000000, 32'h0, 1'b0};
        v[7] = '{32'h00000001, 32'h0, 16'h2000, 16'h0, 32'h00000001, 32'h0, 1'b0};
`else
        v[6] = '{32'hFFFFFFFF, 32'h0, 16'h0001, 16'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        v[7] = '{32'h00000001, 32'h0, 16'h2000, 16'h0, 32'h00000000, 32'h0, 1'b0};
`endif
        v[8] = '{32'h00030000, 32'hFFFE0000, 16'h2000, 16'hE000, 32'h00008000, 32'hFFFD8000, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_re = v[i].xr; x_im = v[i].xi; w_re = v[i].wr; w_im = v[i].wi;
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
            end while (out_valid !== 1'b1 && lat < 20);
            checks++; if (lat != 3) begin errors++; $display("FAIL vec%0d_latency: got %0d want 3", i, lat); end
            checks++; if (y_re !== v[i].er) begin errors++; $display("FAIL vec%0d_re: got %h want %h", i, y_re, v[i].er); end
            checks++; if (y_im !== v[i].ei) begin errors++; $display("FAIL vec%0d_im: got %h want %h", i, y_im, v[i].ei); end
            checks++; if (y_sat !== v[i].es) begin errors++; $display("FAIL vec%0d_sat: got %b want %b", i, y_sat, v[i].es); end
            checks++; if (y_idx !== 6'(idx_model)) begin errors++; $display("FAIL vec%0d_idx: got %0d want %0d", i, y_idx, 6'(idx_model)); end
            idx_model++;
        end
    endtask

    task automatic test_backpressure;
        int sent = 0, rcv = 0, cyc = 0, stalls = 0;
        w_re = 16'h4000; w_im = 16'h0000;  // multiply by 1
        while (rcv < 20 && cyc < 100) begin
            @(negedge clk);
            out_ready = (cyc < 8 || cyc >= 13);
            #1;
            if (out_valid === 1'b1) begin
                checks++; if (y_re !== 32'(rcv * 5 + 100000)) begin errors++; $display("FAIL bp_re[%0d]: got %h want %h", rcv, y_re, 32'(rcv * 5 + 100000)); end
                checks++; if (y_im !== 32'(-rcv)) begin errors++; $display("FAIL bp_im[%0d]: got %h want %h", rcv, y_im, 32'(-rcv)); end
                checks++; if (y_idx !== 6'(idx_model)) begin errors++; $display("FAIL bp_idx[%0d]: got %0d want %0d", rcv, y_idx, 6'(idx_model)); end
                if (out_ready) begin
                    rcv++; idx_model++;
                end else begin
                    stalls++;
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                end
            end
            if (sent < 20) begin
                in_valid = 1'b1;
                x_re = 32'(sent * 5 + 100000);
                x_im = 32'(-sent);
                if (in_ready === 1'b1) sent++;
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcv != 20) begin errors++; $display("FAIL bp_count: got %0d want 20", rcv); end
        checks++; if (stalls != 5) begin errors++; $display("FAIL bp_stalls: got %0d want 5", stalls); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        int lat;
        out_ready = 1'b1; w_re = 16'h4000; w_im = 16'h0000; x_im = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_re = 32'(17 * (k + 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
        rst = 1'b1;  // coincides with an output transfer: reset must win
        @(negedge clk);
        rst = 1'b0;
        idx_model = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (y_idx !== 6'd0) begin errors++; $display("FAIL mid_idx: got %0d want 0", y_idx); end
        checks++; if (y_re !== 32'h0 || y_sat !== 1'b0) begin errors++; $display("FAIL mid_y: got %h/%b want 0/0", y_re, y_sat); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed[%0d]: got %b want 0", k, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b1; x_re = 32'h00001234;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        checks++; if (lat != 3) begin errors++; $display("FAIL mid_after_latency: got %0d want 3", lat); end
        checks++; if (y_re !== 32'h00001234) begin errors++; $display("FAIL mid_after_re: got %h want 00001234", y_re); end
        checks++; if (y_idx !== 6'd0) begin errors++; $display("FAIL mid_after_idx: got %0d want 0", y_idx); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
